// File: rtl/data_mem_resp_if.sv
// Request/response bundle between an initiator and the data_mem_resp memory model.
// The initiator holds each request level until the matching ok pulse arrives.
interface data_mem_resp_if;
    logic        ren;
    logic [63:0] raddr;
    logic [63:0] rdata;
    logic        wen;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic        sig_memread_ok;
    logic        sig_memwrite_ok;
    logic        addr_err;
    logic        busy;

    modport master (
        output ren, raddr, wen, waddr, wdata, wmask,
        input  rdata, sig_memread_ok, sig_memwrite_ok, addr_err, busy
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata, wmask,
        output rdata, sig_memread_ok, sig_memwrite_ok, addr_err, busy
    );
endinterface

// File: rtl/data_mem_resp.sv
// Fixed-latency 64-bit data RAM with level request / pulse completion handshake,
// bit-granular write mask and out-of-range detection.
module data_mem_resp #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2   // 1..15
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_resp_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // One bit wider than the address so the top-of-range bound cannot wrap.
    localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'd8 << DEPTH_LOG2);

    typedef logic [DEPTH_LOG2-1:0] index_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RD_HOLD,
        WR_HOLD
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept_rd, accept_wr;
    logic        rd_ok, wr_ok, load_rd;
    logic [63:0] addr_q, wdata_q, wmask_q;
    logic [63:0] rd_addr;
    logic [63:0] rdata_q;
    logic [63:0] mem [DEPTH];

    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic index_t index_of(input logic [63:0] a);
        return index_t'((a - BASE_ADDR) >> 3);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ren) begin
                    accept_rd  = 1'b1;
                    cnt_next   = 4'(LATENCY);
                    state_next = RD_WAIT;
                end else if (bus.wen) begin
                    accept_wr  = 1'b1;
                    cnt_next   = 4'(LATENCY);
                    state_next = WR_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = RD_HOLD;
            end
            WR_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) state_next = WR_HOLD;
            end
            RD_HOLD: if (!bus.ren) state_next = IDLE;
            WR_HOLD: if (!bus.wen) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rd_ok = (state == RD_WAIT) && (cnt == 4'd1);
    assign wr_ok = (state == WR_WAIT) && (cnt == 4'd1);

    // rdata must be valid from the first cycle of the ok window, so it is loaded
    // on the edge that enters it; with LATENCY=1 that is the accept edge itself.
    assign load_rd = (state_next == RD_WAIT) && (cnt_next == 4'd1);
    assign rd_addr = (state == IDLE) ? bus.raddr : addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 64'h0;
        end else if (load_rd) begin
            rdata_q <= in_range(rd_addr) ? mem[index_of(rd_addr)] : 64'h0;
        end
    end

    // Request operands are sampled once at accept and ignored afterwards.
    always_ff @(posedge clk) begin
        if (accept_rd) begin
            addr_q <= bus.raddr;
        end else if (accept_wr) begin
            addr_q  <= bus.waddr;
            wdata_q <= bus.wdata;
            wmask_q <= bus.wmask;
        end
    end

    // NOTE: the RAM array has no reset branch; contents survive reset and a
    // reset on a RAM would force it into flops instead of a memory macro.
    always_ff @(posedge clk) begin
        if (rst && wr_ok && in_range(addr_q)) begin
            mem[index_of(addr_q)] <= (mem[index_of(addr_q)] & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

    assign bus.rdata           = rdata_q;
    assign bus.sig_memread_ok  = rd_ok;
    assign bus.sig_memwrite_ok = wr_ok;
    assign bus.addr_err        = (rd_ok || wr_ok) && !in_range(addr_q);
    assign bus.busy            = (state != IDLE);

endmodule
